// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one RV32I integer instruction into ALU operands,
// opcode and invert control, and holds them in a single-entry valid/ready stage.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_in1,
  output logic [XLEN-1:0] out_alu_in2,
  output logic [2:0]      out_aluop,
  output logic            out_invert,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      shamt;
  logic [4:0]      rd;
  logic [XLEN-1:0] dec_in1;
  logic [XLEN-1:0] dec_in2;
  logic [2:0]      dec_op;
  logic            dec_inv;
  logic            dec_illegal;
  logic            load;
  logic            unused_rs1_field;

  assign opcode           = in_instr[6:0];
  assign rd               = in_instr[11:7];
  assign funct3           = in_instr[14:12];
  assign shamt            = in_instr[24:20];
  assign funct7           = in_instr[31:25];
  assign unused_rs1_field = ^in_instr[19:15];

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    dec_in1     = '0;
    dec_in2     = '0;
    dec_op      = '0;
    dec_inv     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_in1 = rs1_data;
        dec_in2 = rs2_data;
        dec_op  = funct3;
        if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            dec_in2 = '0 - rs2_data;
          end else if (funct3 == 3'b101) begin
            // ALU re-complements operand 2, restoring the shift amount
            dec_in2 = ~rs2_data;
            dec_inv = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (funct7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_in1 = rs1_data;
        dec_in2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        dec_op  = funct3;
        if (funct3 == 3'b001) begin
          dec_in2 = {{(XLEN-5){1'b0}}, shamt};
          if (funct7 != 7'b0000000) dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_in2 = {{(XLEN-5){1'b0}}, shamt};
          if (funct7 == 7'b0100000) begin
            dec_in2 = ~{{(XLEN-5){1'b0}}, shamt};
            dec_inv = 1'b1;
          end else if (funct7 != 7'b0000000) begin
            dec_illegal = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec_in2 = {in_instr[31:12], {(XLEN-20){1'b0}}};
      end
      OPC_AUIPC: begin
        dec_in1 = XLEN'(in_pc);
        dec_in2 = {in_instr[31:12], {(XLEN-20){1'b0}}};
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_in1 = '0;
      dec_in2 = '0;
      dec_op  = '0;
      dec_inv = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_alu_in1 <= '0;
      out_alu_in2 <= '0;
      out_aluop   <= '0;
      out_invert  <= 1'b0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      out_pc      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_alu_in1 <= dec_in1;
      out_alu_in2 <= dec_in2;
      out_aluop   <= dec_op;
      out_invert  <= dec_inv;
      out_rd      <= rd;
      out_we      <= !dec_illegal && (rd != 5'd0);
      out_illegal <= dec_illegal;
      out_pc      <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
